// File: rtl/peripheral_ahb_sram_ws_if.sv
// AHB-Lite bus bundle between an interconnect master port and one SRAM slave.
// HREADY is driven by the interconnect, so it sits on the master side with the other request signals.
interface peripheral_ahb_sram_ws_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/peripheral_ahb_sram_ws.sv
// AHB-Lite single-port SRAM slave: programmable wait states, byte-lane writes, two-cycle ERROR responses.
// Data phase stalls WAIT_STATES cycles (+1 on registered reads); a read right behind a write is forwarded without stalling.
module peripheral_ahb_sram_ws #(
  parameter int    MEM_SIZE          = 1024,
  parameter int    PLEN              = 32,
  parameter int    XLEN              = 32,
  parameter int    WAIT_STATES       = 0,
  parameter string REGISTERED_OUTPUT = "NO"
) (
  input logic                     HCLK,
  input logic                     HRESET,
  peripheral_ahb_sram_ws_if.slave ahb
);
  localparam int BE      = XLEN / 8;
  localparam int BA      = $clog2(BE);
  localparam int AW      = $clog2(MEM_SIZE);
  localparam int WORDS   = MEM_SIZE / BE;
  localparam bit REG_OUT = (REGISTERED_OUTPUT == "YES");

  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_ws_range
    $error("WAIT_STATES must be in 0..7");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-BA-1:0]  idx_q, idx_d;
  logic [BE-1:0]     be_q, be_d;
  logic              wr_q, wr_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [XLEN-1:0]   hrdata_q, hrdata_d;

  logic [XLEN-1:0]   mem [WORDS];

  logic              accept;
  logic              acc_err;
  logic [BE-1:0]     acc_mask;
  logic [BE-1:0]     acc_be;
  logic [AW-BA-1:0]  acc_idx;
  logic [3:0]        acc_wait;
  logic              commit;
  logic [XLEN-1:0]   wr_word;
  logic [AW-BA-1:0]  rd_idx;
  logic              load_rd;

  logic unused_bus;
  assign unused_bus = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0]};

  assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign commit = (state_q == ST_DATA) & wr_q;

  // Address-phase decode: lane mask, error classification and stall length.
  always_comb begin
    acc_mask = BE'((32'd1 << (32'd1 << ahb.HSIZE)) - 32'd1);
    acc_be   = acc_mask << ahb.HADDR[BA-1:0];
    acc_idx  = ahb.HADDR[AW-1:BA];
    acc_err  = (ahb.HADDR >= PLEN'(MEM_SIZE)) ||
               (ahb.HSIZE > 3'(BA)) ||
               (|(ahb.HADDR[BA-1:0] & BA'((32'd1 << ahb.HSIZE) - 32'd1)));
    acc_wait = 4'(WAIT_STATES) + ((REG_OUT && !ahb.HWRITE) ? 4'd1 : 4'd0);
  end

  // Word being committed; doubles as the forwarded value for a read of the same word.
  always_comb begin
    wr_word = mem[idx_q];
    for (int i = 0; i < BE; i++) begin
      if (be_q[i]) wr_word[8*i +: 8] = ahb.HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    be_d     = be_q;
    wr_d     = wr_q;
    hrdata_d = hrdata_q;
    rd_idx   = idx_q;
    load_rd  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DATA;
          load_rd = !wr_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          idx_d = acc_idx;
          be_d  = acc_be;
          wr_d  = ahb.HWRITE;
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (acc_wait != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(acc_wait - 4'd1);
          end else begin
            state_d = ST_DATA;
            load_rd = !ahb.HWRITE;
            rd_idx  = acc_idx;
          end
        end
      end
    endcase
    if (load_rd) hrdata_d = (commit && rd_idx == idx_q) ? wr_word : mem[rd_idx];
    hreadyout_d = !(state_d inside {ST_WAIT, ST_ERR1});
    hresp_d     = state_d inside {ST_ERR1, ST_ERR2};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      be_q        <= '0;
      wr_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      wr_q        <= wr_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      if (commit) mem[idx_q] <= wr_word;
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = hrdata_q;
endmodule
